mem_access: RTL

Memory-access stage directly downstream of the execute-stage ALU. Latches the ALU result, the store data and the memory-op code, then either passes a non-memory result straight to writeback or runs a byte/word load or store over a req/ack data-memory port, stalling execute until the access completes. Produces one registered writeback record per accepted instruction, or an exception record for overflow or misalignment.

---
 rtl/mem_access_if.sv | 49 ++++
 rtl/mem_access.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Bundle of the execute-side handshake, the data-memory req/ack port and the
// writeback record seen by the mem_access stage.
interface mem_access_if #(
   parameter int REG_SIZE = 32
);
   // Execute -> stage uses valid/ready: a transfer happens on any rising clk edge
   // where ex_valid && ex_ready. Memory uses req/ack: the request and its payload
   // are held until the edge where mem_ack is sampled high with mem_req high.
   logic                    ex_valid;
   logic                    ex_ready;
   logic [REG_SIZE-1:0]     ex_alu_out;
   logic                    ex_overflow;
   logic [REG_SIZE-1:0]     ex_store_data;
   logic [2:0]              ex_memop;
   logic [4:0]              ex_rd;
   logic                    ex_regwrite;

   logic                    mem_req;
   logic                    mem_we;
   logic [REG_SIZE-1:0]     mem_addr;
   logic [REG_SIZE/8-1:0]   mem_be;
   logic [REG_SIZE-1:0]     mem_wdata;
   logic                    mem_ack;
   logic [REG_SIZE-1:0]     mem_rdata;

   logic                    wb_valid;
   logic [4:0]              wb_rd;
   logic                    wb_regwrite;
   logic [REG_SIZE-1:0]     wb_data;
   logic                    wb_exc;

   // master: the mem_access stage itself
   modport master (
      input  ex_valid, ex_alu_out, ex_overflow, ex_store_data, ex_memop, ex_rd, ex_regwrite,
      output ex_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata,
      output wb_valid, wb_rd, wb_regwrite, wb_data, wb_exc
   );

   // slave: execute stage, data memory and writeback consumer around it
   modport slave (
      output ex_valid, ex_alu_out, ex_overflow, ex_store_data, ex_memop, ex_rd, ex_regwrite,
      input  ex_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata,
      input  wb_valid, wb_rd, wb_regwrite, wb_data, wb_exc
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results, runs byte/word loads and
// stores over a req/ack port, and emits one registered writeback record per op.
module mem_access #(
   parameter int REG_SIZE = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_access_if.master  bus,
   output logic          dbg_state
);
   localparam int LANES  = REG_SIZE / 8;
   localparam int LANE_W = $clog2(LANES);

   localparam logic [2:0] OP_LDB = 3'd1;
   localparam logic [2:0] OP_LDW = 3'd2;
   localparam logic [2:0] OP_STB = 3'd3;
   localparam logic [2:0] OP_STW = 3'd4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t state, state_n;

   // memory port registers
   logic                mem_req_q, mem_req_n;
   logic                mem_we_q, mem_we_n;
   logic [REG_SIZE-1:0] mem_addr_q, mem_addr_n;
   logic [LANES-1:0]    mem_be_q, mem_be_n;
   logic [REG_SIZE-1:0] mem_wdata_q, mem_wdata_n;

   // instruction context held across the access
   logic [2:0]          op_q, op_n;
   logic [4:0]          rd_q, rd_n;
   logic                regwrite_q, regwrite_n;
   logic [LANE_W-1:0]   lane_q, lane_n;

   // writeback record registers
   logic                wb_valid_q, wb_valid_n;
   logic [4:0]          wb_rd_q, wb_rd_n;
   logic                wb_regwrite_q, wb_regwrite_n;
   logic [REG_SIZE-1:0] wb_data_q, wb_data_n;
   logic                wb_exc_q, wb_exc_n;

   // decode of the op currently offered by execute
   logic                ex_is_load, ex_is_store, ex_is_word, ex_misaligned;
   logic [LANE_W-1:0]   ex_lane;
   logic [7:0]          ld_byte;

   assign ex_lane       = bus.ex_alu_out[LANE_W-1:0];
   assign ex_is_load    = (bus.ex_memop == OP_LDB) || (bus.ex_memop == OP_LDW);
   assign ex_is_store   = (bus.ex_memop == OP_STB) || (bus.ex_memop == OP_STW);
   assign ex_is_word    = (bus.ex_memop == OP_LDW) || (bus.ex_memop == OP_STW);
   assign ex_misaligned = ex_is_word && (ex_lane != '0);

   // byte lane k of the returned word is bits [8k+7:8k]
   assign ld_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_be_q      <= '0;
         mem_wdata_q   <= '0;
         op_q          <= '0;
         rd_q          <= '0;
         regwrite_q    <= 1'b0;
         lane_q        <= '0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_regwrite_q <= 1'b0;
         wb_data_q     <= '0;
         wb_exc_q      <= 1'b0;
      end else begin
         state         <= state_n;
         mem_req_q     <= mem_req_n;
         mem_we_q      <= mem_we_n;
         mem_addr_q    <= mem_addr_n;
         mem_be_q      <= mem_be_n;
         mem_wdata_q   <= mem_wdata_n;
         op_q          <= op_n;
         rd_q          <= rd_n;
         regwrite_q    <= regwrite_n;
         lane_q        <= lane_n;
         wb_valid_q    <= wb_valid_n;
         wb_rd_q       <= wb_rd_n;
         wb_regwrite_q <= wb_regwrite_n;
         wb_data_q     <= wb_data_n;
         wb_exc_q      <= wb_exc_n;
      end
   end

   always_comb begin
      state_n       = state;
      mem_req_n     = mem_req_q;
      mem_we_n      = mem_we_q;
      mem_addr_n    = mem_addr_q;
      mem_be_n      = mem_be_q;
      mem_wdata_n   = mem_wdata_q;
      op_n          = op_q;
      rd_n          = rd_q;
      regwrite_n    = regwrite_q;
      lane_n        = lane_q;
      wb_valid_n    = 1'b0;
      wb_rd_n       = wb_rd_q;
      wb_regwrite_n = wb_regwrite_q;
      wb_data_n     = wb_data_q;
      wb_exc_n      = wb_exc_q;

      case (state)
         IDLE: begin
            if (bus.ex_valid) begin
               if (bus.ex_overflow || ex_misaligned) begin
                  // faulting op never reaches memory; report the ALU value/address
                  wb_valid_n    = 1'b1;
                  wb_rd_n       = bus.ex_rd;
                  wb_regwrite_n = 1'b0;
                  wb_data_n     = bus.ex_alu_out;
                  wb_exc_n      = 1'b1;
               end else if (ex_is_load || ex_is_store) begin
                  state_n     = ACCESS;
                  mem_req_n   = 1'b1;
                  mem_we_n    = ex_is_store;
                  mem_addr_n  = {bus.ex_alu_out[REG_SIZE-1:LANE_W], {LANE_W{1'b0}}};
                  mem_be_n    = ex_is_word ? {LANES{1'b1}}
                                           : ({{(LANES-1){1'b0}}, 1'b1} << ex_lane);
                  if (!ex_is_store)
                     mem_wdata_n = '0;
                  else if (ex_is_word)
                     mem_wdata_n = bus.ex_store_data;
                  else
                     mem_wdata_n = {LANES{bus.ex_store_data[7:0]}};
                  op_n        = bus.ex_memop;
                  rd_n        = bus.ex_rd;
                  regwrite_n  = bus.ex_regwrite;
                  lane_n      = ex_lane;
               end else begin
                  wb_valid_n    = 1'b1;
                  wb_rd_n       = bus.ex_rd;
                  wb_regwrite_n = bus.ex_regwrite;
                  wb_data_n     = bus.ex_alu_out;
                  wb_exc_n      = 1'b0;
               end
            end
         end

         ACCESS: begin
            if (bus.mem_ack) begin
               state_n    = IDLE;
               mem_req_n  = 1'b0;
               wb_valid_n = 1'b1;
               wb_rd_n    = rd_q;
               wb_exc_n   = 1'b0;
               case (op_q)
                  OP_LDW: begin
                     wb_data_n     = bus.mem_rdata;
                     wb_regwrite_n = regwrite_q;
                  end
                  OP_LDB: begin
                     wb_data_n     = {{(REG_SIZE-8){ld_byte[7]}}, ld_byte};
                     wb_regwrite_n = regwrite_q;
                  end
                  default: begin
                     wb_data_n     = '0;
                     wb_regwrite_n = 1'b0;
                  end
               endcase
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign bus.ex_ready    = (state == IDLE);
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_be      = mem_be_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_regwrite = wb_regwrite_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_exc      = wb_exc_q;
   assign dbg_state       = (state == ACCESS);
endmodule
